// File: rtl/trigger_match.sv
// ---------------------------------------------------------------------------
// trigger_match
//   Match engine for hardware triggers t0/t1. Keeps a private copy of each
//   trigger's mcontrol word, captured from the shared tdata1 one cycle after a
//   committed write. Compares fetch PC and load/store addresses against
//   tdata2_t0/tdata2_t1 and raises one registered request at a time.
//
// Ports
//   i_cpu_clk, i_cpu_rstn      clock, asynchronous active-low reset
//   i_tselect                  selected trigger (capture target and readback)
//   i_tdata1, i_tdata1_wr      shared tdata1 value and its write-commit pulse
//   i_tdata2_t0, i_tdata2_t1   per-trigger compare values
//   i_dbg_mode                 core in debug mode, blocks all matching
//   i_pc_valid, i_pc           instruction entering execute
//   i_ls_valid, i_ls_store,
//   i_ls_addr                  load/store access (i_ls_store=1 means store)
//   i_trig_ack                 request accepted by exception/debug control
//   o_mctrl_rd_data            selected trigger's control copy incl. hit bit
//   o_trig_req                 request pending
//   o_trig_action              0 = breakpoint exception, 1 = enter debug
//   o_trig_idx                 trigger reported
//   o_trig_addr                PC or address that matched
//   o_fsm_state                request FSM state (0 = IDLE, 1 = REQ)
//
// Handshake: o_trig_req rises together with stable idx/action/addr. They hold
// until a cycle in which i_trig_ack is high while the request is pending; the
// request drops in the following cycle. Ack outside a pending request is
// ignored, and hits arriving while a request is pending are dropped.
// ---------------------------------------------------------------------------
module trigger_match #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_cpu_clk,
  input  logic                  i_cpu_rstn,
  input  logic                  i_tselect,
  input  logic [DATA_WIDTH-1:0] i_tdata1,
  input  logic                  i_tdata1_wr,
  input  logic [DATA_WIDTH-1:0] i_tdata2_t0,
  input  logic [DATA_WIDTH-1:0] i_tdata2_t1,
  input  logic                  i_dbg_mode,
  input  logic                  i_pc_valid,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_ls_valid,
  input  logic                  i_ls_store,
  input  logic [DATA_WIDTH-1:0] i_ls_addr,
  input  logic                  i_trig_ack,
  output logic [DATA_WIDTH-1:0] o_mctrl_rd_data,
  output logic                  o_trig_req,
  output logic                  o_trig_action,
  output logic                  o_trig_idx,
  output logic [DATA_WIDTH-1:0] o_trig_addr,
  output logic                  o_fsm_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic                  r_wr_q;
  logic [DATA_WIDTH-1:0] r_ctrl_t0, r_ctrl_t1;
  logic                  r_xhit0, r_xhit1, r_lhit0, r_lhit1;
  logic [DATA_WIDTH-1:0] r_s1_pc, r_s1_ls_addr;
  logic [0:0]            r_state;
  logic                  r_trig_req, r_trig_action, r_trig_idx;
  logic [DATA_WIDTH-1:0] r_trig_addr;

  // Unsigned compare selected by the mcontrol match field.
  function automatic logic f_cmp(input logic [3:0] match,
                                 input logic [DATA_WIDTH-1:0] tdata2,
                                 input logic [DATA_WIDTH-1:0] addr);
    case (match)
      4'd0:    f_cmp = (addr == tdata2);
      4'd2:    f_cmp = (addr >= tdata2);
      4'd3:    f_cmp = (addr <  tdata2);
      default: f_cmp = 1'b0;
    endcase
  endfunction

  // ---------------- stage 1: raw per-trigger hits ----------------
  logic w_en0, w_en1, w_xhit0, w_xhit1, w_lhit0, w_lhit1;

  assign w_en0 = (r_ctrl_t0[31:28] == 4'd2) & r_ctrl_t0[6] & ~i_dbg_mode;
  assign w_en1 = (r_ctrl_t1[31:28] == 4'd2) & r_ctrl_t1[6] & ~i_dbg_mode;

  assign w_xhit0 = w_en0 & r_ctrl_t0[2] & i_pc_valid &
                   f_cmp(r_ctrl_t0[10:7], i_tdata2_t0, i_pc);
  assign w_xhit1 = w_en1 & r_ctrl_t1[2] & i_pc_valid &
                   f_cmp(r_ctrl_t1[10:7], i_tdata2_t1, i_pc);
  assign w_lhit0 = w_en0 & i_ls_valid &
                   ((r_ctrl_t0[0] & ~i_ls_store) | (r_ctrl_t0[1] & i_ls_store)) &
                   f_cmp(r_ctrl_t0[10:7], i_tdata2_t0, i_ls_addr);
  assign w_lhit1 = w_en1 & i_ls_valid &
                   ((r_ctrl_t1[0] & ~i_ls_store) | (r_ctrl_t1[1] & i_ls_store)) &
                   f_cmp(r_ctrl_t1[10:7], i_tdata2_t1, i_ls_addr);

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_wr_q       <= 1'b0;
      r_xhit0      <= 1'b0;
      r_xhit1      <= 1'b0;
      r_lhit0      <= 1'b0;
      r_lhit1      <= 1'b0;
      r_s1_pc      <= '0;
      r_s1_ls_addr <= '0;
    end else begin
      r_wr_q       <= i_tdata1_wr;
      r_xhit0      <= w_xhit0;
      r_xhit1      <= w_xhit1;
      r_lhit0      <= w_lhit0;
      r_lhit1      <= w_lhit1;
      r_s1_pc      <= i_pc;
      r_s1_ls_addr <= i_ls_addr;
    end
  end

  // ---------------- stage 2: chain, priority, single winner ----------------
  // With chain set the pair acts as one trigger reported as idx 1: it needs
  // both hits on the same source, and neither member fires on its own.
  logic                  w_chain, w_xfire, w_lfire, w_fire, w_idx, w_action;
  logic                  w_xidx, w_lidx, w_accept, w_set0, w_set1;
  logic [DATA_WIDTH-1:0] w_addr;

  assign w_chain  = r_ctrl_t0[11];
  assign w_xfire  = w_chain ? (r_xhit0 & r_xhit1) : (r_xhit0 | r_xhit1);
  assign w_lfire  = w_chain ? (r_lhit0 & r_lhit1) : (r_lhit0 | r_lhit1);
  assign w_xidx   = w_chain | ~r_xhit0;
  assign w_lidx   = w_chain | ~r_lhit0;
  assign w_fire   = w_xfire | w_lfire;
  assign w_idx    = w_xfire ? w_xidx : w_lidx;
  assign w_addr   = w_xfire ? r_s1_pc : r_s1_ls_addr;
  assign w_action = w_idx ? (r_ctrl_t1[15:12] == 4'd1) : (r_ctrl_t0[15:12] == 4'd1);
  assign w_accept = (r_state == ST_IDLE) & w_fire;
  assign w_set0   = w_accept & (~w_idx | w_chain);
  assign w_set1   = w_accept & w_idx;

  // Control copies: a pending capture overrides a hit-bit set in the same
  // cycle, so the written hit value is what software sees.
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_ctrl_t0 <= '0;
      r_ctrl_t1 <= '0;
    end else begin
      if (r_wr_q && !i_tselect) r_ctrl_t0     <= i_tdata1;
      else if (w_set0)          r_ctrl_t0[20] <= 1'b1;
      if (r_wr_q && i_tselect)  r_ctrl_t1     <= i_tdata1;
      else if (w_set1)          r_ctrl_t1[20] <= 1'b1;
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_state       <= ST_IDLE;
      r_trig_req    <= 1'b0;
      r_trig_action <= 1'b0;
      r_trig_idx    <= 1'b0;
      r_trig_addr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state       <= ST_REQ;
            r_trig_req    <= 1'b1;
            r_trig_idx    <= w_idx;
            r_trig_action <= w_action;
            r_trig_addr   <= w_addr;
          end
        end
        ST_REQ: begin
          if (i_trig_ack) begin
            r_state    <= ST_IDLE;
            r_trig_req <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mctrl_rd_data = i_tselect ? r_ctrl_t1 : r_ctrl_t0;
  assign o_trig_req      = r_trig_req;
  assign o_trig_action   = r_trig_action;
  assign o_trig_idx      = r_trig_idx;
  assign o_trig_addr     = r_trig_addr;
  assign o_fsm_state     = r_state;

endmodule

// File: tb/tb_trigger_match.sv
module tb_trigger_match;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic        tselect, tdata1_wr, dbg, pc_valid, ls_valid, ls_store, ack;
  logic [31:0] tdata1, t2_0, t2_1, pc, ls_addr;
  logic [31:0] rd_data, trig_addr;
  logic        trig_req, trig_action, trig_idx, fsm_state;

  trigger_match #(.DATA_WIDTH(32)) dut (
    .i_cpu_clk(clk), .i_cpu_rstn(rstn), .i_tselect(tselect),
    .i_tdata1(tdata1), .i_tdata1_wr(tdata1_wr),
    .i_tdata2_t0(t2_0), .i_tdata2_t1(t2_1), .i_dbg_mode(dbg),
    .i_pc_valid(pc_valid), .i_pc(pc),
    .i_ls_valid(ls_valid), .i_ls_store(ls_store), .i_ls_addr(ls_addr),
    .i_trig_ack(ack), .o_mctrl_rd_data(rd_data), .o_trig_req(trig_req),
    .o_trig_action(trig_action), .o_trig_idx(trig_idx),
    .o_trig_addr(trig_addr), .o_fsm_state(fsm_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected request = {idx, action, addr}.
  logic [33:0] exp_q[$];
  logic [31:0] m_ctrl [2];
  logic        m_wr_q, m_req, m_idx, m_action;
  logic        m_x [2];
  logic        m_l [2];
  logic [31:0] m_pc, m_ls, m_addr;

  function automatic logic ref_cmp(input logic [3:0] match, input logic [31:0] t2,
                                   input logic [31:0] a);
    if (match == 4'd0) return a == t2;
    if (match == 4'd2) return a >= t2;
    if (match == 4'd3) return a < t2;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ctrl[0] = 0; m_ctrl[1] = 0; m_wr_q = 0; m_req = 0; m_idx = 0;
    m_action = 0; m_addr = 0; m_pc = 0; m_ls = 0;
    for (int t = 0; t < 2; t++) begin m_x[t] = 0; m_l[t] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] c [2];
    logic [31:0] t2 [2];
    logic chain, hx, hl, idx, en;
    logic [31:0] addr;
    c[0] = m_ctrl[0]; c[1] = m_ctrl[1];
    t2[0] = t2_0; t2[1] = t2_1;
    chain = c[0][11];
    // a chained pair needs both members on one source; else any member wins
    hx = chain ? (m_x[0] && m_x[1]) : (m_x[0] || m_x[1]);
    hl = chain ? (m_l[0] && m_l[1]) : (m_l[0] || m_l[1]);
    if (hx) begin idx = chain || !m_x[0]; addr = m_pc; end
    else    begin idx = chain || !m_l[0]; addr = m_ls; end
    if (m_req) begin
      if (ack) m_req = 0;
    end else if (hx || hl) begin
      m_req = 1; m_idx = idx; m_addr = addr;
      m_action = (c[idx][15:12] == 4'd1);
      c[idx][20] = 1'b1;
      if (chain) c[0][20] = 1'b1;
      exp_q.push_back({m_idx, m_action, m_addr});
    end
    if (m_wr_q) c[tselect] = tdata1;
    for (int t = 0; t < 2; t++) begin
      en = (m_ctrl[t][31:28] == 4'd2) && m_ctrl[t][6] && !dbg;
      m_x[t] = en && m_ctrl[t][2] && pc_valid && ref_cmp(m_ctrl[t][10:7], t2[t], pc);
      m_l[t] = en && ls_valid && (ls_store ? m_ctrl[t][1] : m_ctrl[t][0]) &&
               ref_cmp(m_ctrl[t][10:7], t2[t], ls_addr);
    end
    m_pc = pc; m_ls = ls_addr; m_wr_q = tdata1_wr;
    m_ctrl[0] = c[0]; m_ctrl[1] = c[1];
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // ---------------- per-cycle level checks ----------------
  always @(negedge clk) begin
    if (rstn) begin
      chk("req_level", {31'd0, trig_req}, {31'd0, m_req});
      chk("fsm_state", {31'd0, fsm_state}, {31'd0, m_req});
      chk("readback", rd_data, m_ctrl[tselect]);
      if (m_req) begin
        chk("hold_idx", {31'd0, trig_idx}, {31'd0, m_idx});
        chk("hold_action", {31'd0, trig_action}, {31'd0, m_action});
        chk("hold_addr", trig_addr, m_addr);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic seen_req = 1'b0;
  always @(negedge clk or negedge rstn) begin
    if (!rstn) seen_req <= 1'b0;
    else begin
      if (trig_req && !seen_req) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_req actual idx=%0d addr=%h required none", trig_idx, trig_addr);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("sb_idx", {31'd0, trig_idx}, {31'd0, e[33]});
          chk("sb_action", {31'd0, trig_action}, {31'd0, e[32]});
          chk("sb_addr", trig_addr, e[31:0]);
        end
      end
      seen_req <= trig_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_in();
    tdata1_wr = 0; pc_valid = 0; ls_valid = 0; ls_store = 0; ack = 0;
  endtask

  task automatic write_ctrl(input logic sel, input logic [31:0] val);
    tselect = sel; tdata1 = val; tdata1_wr = 1; step();
    tdata1_wr = 0; step(); step();
  endtask

  task automatic fetch(input logic [31:0] a);
    pc_valid = 1; pc = a; step(); pc_valid = 0;
  endtask

  task automatic lsu(input logic st, input logic [31:0] a);
    ls_valid = 1; ls_store = st; ls_addr = a; step(); ls_valid = 0;
  endtask

  task automatic do_ack();
    ack = 1; step(); ack = 0;
    chk("ack_drop", {31'd0, trig_req}, 32'd0);
  endtask

  function automatic logic [31:0] rand_ctrl();
    logic [31:0] c;
    logic [3:0]  mt;
    c = 0;
    c[31:28] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'd2;
    c[20] = 1'($urandom_range(0, 1));
    c[15:12] = 4'($urandom_range(0, 2));
    c[11] = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0: mt = 4'd0;
      1: mt = 4'd2;
      2: mt = 4'd3;
      default: mt = 4'd1;
    endcase
    c[10:7] = mt;
    c[6] = ($urandom_range(0, 5) != 0);
    c[2:0] = 3'($urandom_range(0, 7));
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rstn = 0; tselect = 0; tdata1 = 0; t2_0 = 0; t2_1 = 0; dbg = 0;
    pc = 0; ls_addr = 0; clear_in();
    #13;
    chk("rst_req", {31'd0, trig_req}, 32'd0);
    chk("rst_addr", trig_addr, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_idx_act", {30'd0, trig_idx, trig_action}, 32'd0);
    step(); rstn = 1; step();

    // execute equal on t0
    write_ctrl(0, 32'h2000_0044); t2_0 = 32'h100;
    fetch(32'h100);
    chk("xeq_n1", {31'd0, trig_req}, 32'd0);
    step();
    chk("xeq_req", {31'd0, trig_req}, 32'd1);
    chk("xeq_idx_act", {30'd0, trig_idx, trig_action}, 32'd0);
    chk("xeq_addr", trig_addr, 32'h100);
    chk("xeq_hit", rd_data, 32'h2010_0044);
    do_ack();

    // store range on t1
    write_ctrl(0, 32'h0);
    write_ctrl(1, 32'h2000_1142); t2_1 = 32'h8000;
    lsu(0, 32'h9000); step(); step();
    chk("ld_noreq", {31'd0, trig_req}, 32'd0);
    lsu(1, 32'h7FFC); step(); step();
    chk("st_low_noreq", {31'd0, trig_req}, 32'd0);
    lsu(1, 32'h9000); step();
    chk("st_req", {31'd0, trig_req}, 32'd1);
    chk("st_idx_act", {30'd0, trig_idx, trig_action}, 32'd3);
    do_ack();

    // chain: t0 execute ==0x200, t1 <0x300
    t2_0 = 32'h200; t2_1 = 32'h300;
    write_ctrl(0, 32'h2000_0844);
    write_ctrl(1, 32'h2000_01C1);
    fetch(32'h200); step(); step();
    chk("chain_alone", {31'd0, trig_req}, 32'd0);
    pc_valid = 1; pc = 32'h200; lsu(0, 32'h100); pc_valid = 0; step(); step();
    chk("chain_xsrc", {31'd0, trig_req}, 32'd0);
    write_ctrl(1, 32'h2000_01C5);
    fetch(32'h200); step();
    chk("chain_req", {31'd0, trig_req}, 32'd1);
    chk("chain_idx", {31'd0, trig_idx}, 32'd1);
    tselect = 0; #1 chk("chain_hit0", rd_data, 32'h2010_0844);
    tselect = 1; #1 chk("chain_hit1", rd_data, 32'h2010_01C5);
    do_ack();

    // priority: t0 execute vs t1 load in the same cycle
    t2_0 = 32'h400;
    write_ctrl(0, 32'h2000_0044);
    write_ctrl(1, 32'h2000_01C1);
    pc_valid = 1; pc = 32'h400; lsu(0, 32'h100); pc_valid = 0; step();
    chk("prio_idx", {31'd0, trig_idx}, 32'd0);
    chk("prio_addr", trig_addr, 32'h400);
    tselect = 1; #1 chk("prio_t1_nohit", rd_data, 32'h2000_01C1);

    // back-pressure: keep matching with ack low
    for (int i = 0; i < 5; i++) begin
      pc_valid = 1; pc = 32'h400; ls_valid = 1; ls_store = 0; ls_addr = 32'h10; step();
    end
    clear_in();
    chk("bp_req", {31'd0, trig_req}, 32'd1);
    chk("bp_addr", trig_addr, 32'h400);
    chk("bp_t1_nohit", rd_data, 32'h2000_01C1);
    rstn = 0; #1;
    chk("rst_mid_req", {31'd0, trig_req}, 32'd0);
    chk("rst_mid_addr", trig_addr, 32'd0);
    chk("rst_mid_rd", rd_data, 32'd0);
    step(); rstn = 1; step(); step();
    chk("no_replay", {31'd0, trig_req}, 32'd0);

    // dbg_mode / type gating and hit clearing
    t2_0 = 32'h100;
    write_ctrl(0, 32'h2000_0044);
    dbg = 1; fetch(32'h100); step(); step(); dbg = 0;
    chk("dbg_noreq", {31'd0, trig_req}, 32'd0);
    write_ctrl(0, 32'h0000_0044);
    fetch(32'h100); step(); step();
    chk("type0_noreq", {31'd0, trig_req}, 32'd0);
    write_ctrl(0, 32'h2000_0044);
    fetch(32'h100); step();
    chk("hit_set", rd_data, 32'h2010_0044);
    do_ack();
    tdata1 = 32'h2000_0044; tdata1_wr = 1; step(); tdata1_wr = 0; step();
    chk("hit_clear", rd_data, 32'h2000_0044);
    // capture and hit in the same cycle: capture value wins
    pc_valid = 1; pc = 32'h100; tdata1_wr = 1; step(); clear_in(); step();
    chk("wr_vs_hit_req", {31'd0, trig_req}, 32'd1);
    chk("wr_vs_hit_rd", rd_data, 32'h2000_0044);
    do_ack();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) t2_0 = $urandom_range(0, 15);
      if ($urandom_range(0, 49) == 0) t2_1 = $urandom_range(0, 15);
      tselect   = 1'($urandom_range(0, 1));
      tdata1_wr = ($urandom_range(0, 11) == 0);
      if (tdata1_wr) tdata1 = rand_ctrl();
      dbg       = ($urandom_range(0, 19) == 0);
      pc_valid  = 1'($urandom_range(0, 1));
      pc        = $urandom_range(0, 15);
      ls_valid  = 1'($urandom_range(0, 1));
      ls_store  = 1'($urandom_range(0, 1));
      ls_addr   = $urandom_range(0, 15);
      ack       = ($urandom_range(0, 2) == 0);
      step();
    end
    clear_in(); dbg = 0; ack = 1;
    repeat (4) step();
    ack = 0; step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
